// File: rtl/divider_pkg.sv
// divider_pkg: shared types and defaults for the iterative divider.
package divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } divider_state_t;

   localparam int DIVIDER_DEFAULT_WIDTH = 32;

endpackage

// File: rtl/iterative_divider_if.sv
// iterative_divider_if: operand and result handshake bundle for the divider.
//
// Handshake rules: a transfer happens on a rising clock edge where valid and
// ready are both high. The source holds valid and its payload stable until
// that edge. Ready never depends combinationally on valid.
interface iterative_divider_if
   import divider_pkg::*;
#(
   parameter int WIDTH = DIVIDER_DEFAULT_WIDTH
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;
   divider_state_t   dbg_state;

   // Divider side.
   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero, dbg_state
   );

   // Producer/consumer side.
   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero, dbg_state
   );

endinterface

// File: rtl/divider_step.sv
// divider_step: one combinational restoring-division iteration.
// The partial remainder entering a step is always below the divisor, so the
// shifted value fits in WIDTH+1 bits and the top bit of the wide difference
// is only there to make the comparison exact.
module divider_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH:0]   rem_o,
   output logic             q_bit_o
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;
   logic [WIDTH+1:0] nxt;
   logic             unused_msb;

   // Shift in the next dividend bit, trial-subtract, keep difference if no borrow.
   always_comb begin
      shifted = {rem_i, bit_i};
      diff    = shifted - {2'b00, divisor_i};
      q_bit_o = (shifted >= {2'b00, divisor_i});
      nxt     = q_bit_o ? diff : shifted;
   end

   assign rem_o      = nxt[WIDTH:0];
   assign unused_msb = nxt[WIDTH+1];

endmodule

// File: rtl/iterative_divider.sv
// iterative_divider: multi-cycle radix-2 restoring divider, one operation in
// flight, result held until the consumer accepts it.
// Build option: define DIVIDER_SIGNED_EN for two's-complement operands
// (magnitudes divided, signs applied when the result is registered).
module iterative_divider
   import divider_pkg::*;
#(
   parameter int WIDTH = DIVIDER_DEFAULT_WIDTH
) (
   input logic                clk,
   input logic                reset,
   iterative_divider_if.slave bus
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   divider_state_t   state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   rem_q, rem_d;     // partial remainder
   logic [WIDTH-1:0] work_q, work_d;   // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor (magnitude) for the run
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] remo_q, remo_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   step_rem;
   logic             step_bit;
   logic [WIDTH-1:0] q_mag;
   logic [WIDTH-1:0] r_mag;

`ifdef DIVIDER_SIGNED_EN
   logic             negq_q, negq_d;   // quotient negative
   logic             negr_q, negr_d;   // remainder follows dividend sign

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction
`endif

   divider_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_q),
      .bit_i     (work_q[WIDTH-1]),
      .divisor_i (dvs_q),
      .rem_o     (step_rem),
      .q_bit_o   (step_bit)
   );

   // Next-state and datapath decisions for IDLE/BUSY/DONE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      work_d  = work_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      remo_d  = remo_q;
      dbz_d   = dbz_q;
      q_mag   = {work_q[WIDTH-2:0], step_bit};
      r_mag   = step_rem[WIDTH-1:0];
`ifdef DIVIDER_SIGNED_EN
      negq_d  = negq_q;
      negr_d  = negr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               if (bus.divisor == '0) begin
                  // Zero divisor short-circuits straight to a flagged result.
                  quo_d   = '1;
                  remo_d  = bus.dividend;
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else begin
`ifdef DIVIDER_SIGNED_EN
                  work_d = mag(bus.dividend);
                  dvs_d  = mag(bus.divisor);
                  negq_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                  negr_d = bus.dividend[WIDTH-1];
`else
                  work_d = bus.dividend;
                  dvs_d  = bus.divisor;
`endif
                  rem_d   = '0;
                  cnt_d   = '0;
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            rem_d  = step_rem;
            work_d = q_mag;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               dbz_d   = 1'b0;
               state_d = DONE;
`ifdef DIVIDER_SIGNED_EN
               quo_d  = negq_q ? -q_mag : q_mag;
               remo_d = negr_q ? -r_mag : r_mag;
`else
               quo_d  = q_mag;
               remo_d = r_mag;
`endif
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any division in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         work_q  <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
         remo_q  <= '0;
         dbz_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         work_q  <= work_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
         remo_q  <= remo_d;
         dbz_q   <= dbz_d;
`ifdef DIVIDER_SIGNED_EN
         negq_q  <= negq_d;
         negr_q  <= negr_d;
`endif
      end
   end

   assign bus.in_ready    = (state_q == IDLE);
   assign bus.out_valid   = (state_q == DONE);
   assign bus.quotient    = quo_q;
   assign bus.remainder   = remo_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_iterative_divider.sv
// tb_iterative_divider: directed table, corner sequences and a randomized
// back-to-back stream for iterative_divider at WIDTH=8.
// Honours DIVIDER_SIGNED_EN when the design is built with it.
module tb_iterative_divider;
   import divider_pkg::*;

   localparam int W = 8;

   logic clk = 1'b0;
   logic reset;

   iterative_divider_if #(.WIDTH(W)) bus ();

   iterative_divider #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [2*W:0] exp_q[$];   // {div_by_zero, quotient, remainder}

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      int           lat;
      int           hold;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: plain arithmetic on the operand values.
   function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] q;
      logic [W-1:0] r;
      int sa;
      int sb;
      if (b == '0) return {1'b1, {W{1'b1}}, a};
`ifdef DIVIDER_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
`else
      sa = int'(a);
      sb = int'(b);
      q  = W'(sa / sb);
      r  = W'(sa % sb);
`endif
      return {1'b0, q, r};
   endfunction

   task automatic add(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q,
                      input logic [W-1:0] r, input logic z, input int lat, input int hold);
      vec_t v;
      v.a = a; v.b = b; v.q = q; v.r = r; v.z = z; v.lat = lat; v.hold = hold;
      vecs.push_back(v);
   endtask

   // ---------------- driver tasks ----------------
   // Present operands, wait for in_ready, complete one transfer.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
      int budget;
      budget = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      while (!bus.in_ready && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      check("send_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.dividend = W'($urandom);
      bus.divisor  = W'($urandom);
   endtask

   // Wait for a result, hold it for 'hold' cycles, then consume it.
   task automatic recv(input int hold, output logic [2*W:0] got, output int lat);
      lat = 0;
      bus.out_ready = 1'b0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.out_valid && lat < 200);
      got = {bus.div_by_zero, bus.quotient, bus.remainder};
      check("done_in_ready", 32'(bus.in_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_result", 32'({bus.div_by_zero, bus.quotient, bus.remainder}), 32'(got));
         check("hold_out_valid", 32'(bus.out_valid), 32'd1);
         check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("after_in_ready", 32'(bus.in_ready), 32'd1);
      check("after_out_valid", 32'(bus.out_valid), 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_quotient"}, 32'(bus.quotient), 32'd0);
      check({tag, "_remainder"}, 32'(bus.remainder), 32'd0);
      check({tag, "_div_by_zero"}, 32'(bus.div_by_zero), 32'd0);
      check({tag, "_state"}, 32'(bus.dbg_state), 32'(IDLE));
   endtask

   // ---------------- main test ----------------
   initial begin : main
      logic [2*W:0] got;
      int lat;
      int total;
      int got_n;

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      bus.out_ready = 1'b0;
      #2 reset = 1'b0;
      @(negedge clk);
      check_reset_values("reset");
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Directed vectors: operands, expected quotient/remainder/flag,
      // cycles from acceptance to first out_valid, cycles to stall the result.
      add(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, W + 1, 0);
      add(8'h55, 8'h00, 8'hFF, 8'h55, 1'b1, 1, 3);
`ifdef DIVIDER_SIGNED_EN
      add(8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, W + 1, 5);   // -7 / 2
      add(8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, W + 1, 0);   // 7 / -2
      add(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, W + 1, 0);   // MIN / -1
      add(8'h80, 8'h01, 8'h80, 8'h00, 1'b0, W + 1, 0);   // MIN / 1
      add(8'h7F, 8'hF9, 8'hEE, 8'h01, 1'b0, W + 1, 0);   // 127 / -7
      add(8'hF6, 8'hFD, 8'h03, 8'hFF, 1'b0, W + 1, 0);   // -10 / -3
      add(8'h80, 8'h00, 8'hFF, 8'h80, 1'b1, 1, 0);       // MIN / 0
`else
      add(8'd200, 8'd3, 8'd66, 8'd2, 1'b0, W + 1, 5);
      add(8'd0, 8'd1, 8'd0, 8'd0, 1'b0, W + 1, 0);
      add(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, W + 1, 0);
      add(8'd1, 8'd255, 8'd0, 8'd1, 1'b0, W + 1, 0);
      add(8'd128, 8'd16, 8'd8, 8'd0, 1'b0, W + 1, 0);
      add(8'd250, 8'd251, 8'd0, 8'd250, 1'b0, W + 1, 0);
`endif

      foreach (vecs[i]) begin
         send(vecs[i].a, vecs[i].b);
         recv(vecs[i].hold, got, lat);
         check("vec_quotient", 32'(got[2*W-1:W]), 32'(vecs[i].q));
         check("vec_remainder", 32'(got[W-1:0]), 32'(vecs[i].r));
         check("vec_div_by_zero", 32'(got[2*W]), 32'(vecs[i].z));
         check("vec_latency", 32'(lat), 32'(vecs[i].lat));
      end

      // Reset in the 4th BUSY cycle abandons the operation.
      send(8'd200, 8'd7);
      @(negedge clk);
      check("busy_state", 32'(bus.dbg_state), 32'(BUSY));
      check("busy_in_ready", 32'(bus.in_ready), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check_reset_values("midreset");
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("post_reset_out_valid", 32'(bus.out_valid), 32'd0);
      send(8'd50, 8'd5);
      recv(0, got, lat);
      check("post_reset_result", 32'(got), 32'({1'b0, 8'd10, 8'd0}));
      check("post_reset_latency", 32'(lat), 32'(W + 1));

      // Back-to-back stream, in_valid held high, random consumer stalls.
      total = 32;
      got_n = 0;
      fork
         begin : driver
            logic [W-1:0] a;
            logic [W-1:0] b;
            int budget;
            int sel;
            for (int i = 0; i < total; i++) begin
               if (i == 0) begin
                  a = 8'd255; b = 8'd255;
               end else if (i == 1) begin
                  a = 8'd7; b = 8'd9;
               end else begin
                  sel = int'($urandom_range(0, 7));
                  a = (sel == 1) ? 8'h80 : W'($urandom);
                  b = (sel == 0) ? 8'h00 : (sel < 4) ? W'($urandom_range(1, 3)) : W'($urandom);
               end
               @(negedge clk);
               bus.in_valid = 1'b1;
               bus.dividend = a;
               bus.divisor  = b;
               budget = 0;
               while (!bus.in_ready && budget < 2000) begin
                  @(negedge clk);
                  budget++;
               end
               if (i == 0) exp_q.push_back({1'b0, 8'd1, 8'd0});
               else if (i == 1) exp_q.push_back({1'b0, 8'd0, 8'd7});
               else exp_q.push_back(model(a, b));
               @(posedge clk);
            end
            @(negedge clk);
            bus.in_valid = 1'b0;
         end
         begin : monitor
            int cyc;
            logic [2*W:0] exp;
            cyc = 0;
            while (got_n < total && cyc < 20000) begin
               @(negedge clk);
               cyc++;
               bus.out_ready = ($urandom_range(0, 3) != 0);
               if (bus.out_valid && bus.out_ready) begin
                  if (exp_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL b2b_unexpected got=0x%0h expected=none", {bus.div_by_zero, bus.quotient, bus.remainder});
                  end else begin
                     exp = exp_q.pop_front();
                     check("b2b_result", 32'({bus.div_by_zero, bus.quotient, bus.remainder}), 32'(exp));
                  end
                  got_n++;
               end
            end
            bus.out_ready = 1'b0;
         end
      join
      check("b2b_count", 32'(got_n), 32'(total));
      check("b2b_leftover", 32'(exp_q.size()), 32'd0);

      // ---------------- report ----------------
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
